// File: rtl/seg_disp_arb.sv
// seg_disp_arb: round-robin arbiter that lets one of three requesters own a
// 4-digit seven-segment display for a fixed number of scan ticks. A free
// running prescaler produces the digit-advance strobe; the arbiter latches the
// winner's value into disp_data and holds it for HOLD_TICKS strobes, or less
// if the owner drops its request.
module seg_disp_arb #(
  parameter int SCAN_DIV   = 50000,  // clk cycles per scan_tick (2..65535)
  parameter int HOLD_TICKS = 500     // scan_ticks per grant window (1..1023)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic [15:0] disp_data,
  output logic        scan_tick,
  output logic        switch_p
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
  localparam logic [9:0]  HOLD_MAX  = 10'(HOLD_TICKS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Registered state and outputs
  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic        scan_tick_q, scan_tick_d;
  logic [9:0]  hold_q, hold_d;
  logic [1:0]  last_q, last_d;
  logic [2:0]  grant_q, grant_d;
  logic [15:0] disp_q, disp_d;
  logic        switch_q, switch_d;

  // Arbitration results
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [2:0]  win_onehot;
  logic [15:0] win_data;

  // Handover conditions
  logic        expiry;
  logic        owner_req;
  logic        load;

  // Successor of a requester index in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Free-running prescaler; the strobe fires the cycle after it reaches its top.
  always_comb begin
    presc_d     = (presc_q == PRESC_MAX) ? 16'd0 : presc_q + 16'd1;
    scan_tick_d = (presc_q == PRESC_MAX);
  end

  // Round-robin search starting just after the most recent grantee; the last
  // grantee itself is visited last, so a lone requester is re-granted.
  always_comb begin : arb_search
    logic [1:0] idx;
    idx       = last_q;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx = inc3(idx);
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // One-hot form of the winner index.
  for (genvar gi = 0; gi < 3; gi++) begin : g_onehot
    assign win_onehot[gi] = win_valid && (win_idx == 2'(gi));
  end

  // Select the winner's display value.
  always_comb begin
    case (win_idx)
      2'd0:    win_data = data0;
      2'd1:    win_data = data1;
      default: win_data = data2;
    endcase
  end

  // Next-state logic: load on a new win, count strobes while showing,
  // and hand over on window expiry or when the owner releases early.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    disp_d    = disp_q;
    last_d    = last_q;
    hold_d    = hold_q;
    switch_d  = 1'b0;
    load      = 1'b0;
    expiry    = scan_tick_q && (hold_q == HOLD_MAX);
    owner_req = |(req & grant_q);

    case (state_q)
      IDLE: begin
        grant_d = 3'b000;
        if (win_valid) begin
          load = 1'b1;
        end
      end
      SHOW: begin
        if (expiry || !owner_req) begin
          // Expiry takes precedence; an early release on the same cycle
          // resolves identically because the owner's bit is then clear.
          if (win_valid) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = 3'b000;
            hold_d  = 10'd0;
          end
        end else if (scan_tick_q) begin
          hold_d = hold_q + 10'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase

    if (load) begin
      state_d  = SHOW;
      grant_d  = win_onehot;
      disp_d   = win_data;
      last_d   = win_idx;
      hold_d   = 10'd0;
      switch_d = 1'b1;
    end
  end

  // State and output registers; reset clears everything except last, which
  // points at requester 2 so requester 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_q     <= 16'd0;
      scan_tick_q <= 1'b0;
      hold_q      <= 10'd0;
      last_q      <= 2'd2;
      grant_q     <= 3'b000;
      disp_q      <= 16'h0000;
      switch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      scan_tick_q <= scan_tick_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      disp_q      <= disp_d;
      switch_q    <= switch_d;
    end
  end

  assign grant     = grant_q;
  assign disp_data = disp_q;
  assign scan_tick = scan_tick_q;
  assign switch_p  = switch_q;

endmodule

// File: tb/tb_seg_disp_arb.sv
// tb_seg_disp_arb: directed bench for seg_disp_arb with SCAN_DIV=4 and
// HOLD_TICKS=2, so a full grant window is 8 cycles. Inputs change on the
// falling edge and outputs are sampled on the falling edge.
module tb_seg_disp_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [15:0] data0 = 16'h0000;
  logic [15:0] data1 = 16'h0000;
  logic [15:0] data2 = 16'h0000;
  logic [2:0]  grant;
  logic [15:0] disp_data;
  logic        scan_tick;
  logic        switch_p;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seg_disp_arb #(
    .SCAN_DIV  (4),
    .HOLD_TICKS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .grant    (grant),
    .disp_data(disp_data),
    .scan_tick(scan_tick),
    .switch_p (switch_p)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Assert reset for two cycles, check the cleared outputs, release on a
  // falling edge. The next rising edge is edge 1 after release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 3'b000;
    @(negedge clk);
    check_val("rst_grant", {29'd0, grant}, 32'd0);
    check_val("rst_disp", {16'd0, disp_data}, 32'd0);
    check_val("rst_strobes", {30'd0, scan_tick, switch_p}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0]  gseq [4];
  logic [15:0] dseq [4];

  initial begin
    gseq = '{3'b001, 3'b010, 3'b100, 3'b001};
    dseq = '{16'h1111, 16'h2222, 16'h3333, 16'h1111};

    // Outputs must be cleared by reset alone, before any clock edge.
    #1;
    check_val("init_grant", {29'd0, grant}, 32'd0);
    check_val("init_disp", {16'd0, disp_data}, 32'd0);
    check_val("init_strobes", {30'd0, scan_tick, switch_p}, 32'd0);

    // Scenario 1: idle with no requests; strobe every 4th cycle.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check_val("s1_tick", {31'd0, scan_tick}, {31'd0, (k % 4) == 0});
      check_val("s1_idle", {10'd0, grant, switch_p, disp_data}, 32'd0);
    end
    $display("[TB] scenario 1 idle scan done, %0d checks so far", tests_run);

    // Scenario 2: all three requesting, rotation 0,1,2,0 in 8-cycle windows.
    data0 = 16'h1111;
    data1 = 16'h2222;
    data2 = 16'h3333;
    req   = 3'b111;
    for (int k = 0; k < 32; k++) begin
      step();
      check_val("s2_grant", {29'd0, grant}, {29'd0, gseq[k / 8]});
      check_val("s2_disp", {16'd0, disp_data}, {16'd0, dseq[k / 8]});
      check_val("s2_switch", {31'd0, switch_p}, {31'd0, (k % 8) == 0});
    end
    $display("[TB] scenario 2 rotation done, %0d checks so far", tests_run);

    // Scenario 3: lone requester 1, data changes mid-window.
    do_reset();
    data1 = 16'hABCD;
    req   = 3'b010;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_val("s3_grant", {29'd0, grant}, 32'd2);
      check_val("s3_disp", {16'd0, disp_data}, (k <= 8) ? 32'h0000ABCD : 32'h00001234);
      check_val("s3_switch", {31'd0, switch_p}, {31'd0, (k == 1) || (k == 9)});
      if (k == 3) data1 = 16'h1234;
    end
    $display("[TB] scenario 3 lone requester done, %0d checks so far", tests_run);

    // Scenario 4: grantee 0 drops one cycle in, requester 2 takes over.
    do_reset();
    data0 = 16'h0A0A;
    data2 = 16'h0C0C;
    req   = 3'b101;
    step();
    check_val("s4_grant0", {29'd0, grant}, 32'd1);
    check_val("s4_disp0", {16'd0, disp_data}, 32'h00000A0A);
    check_val("s4_sw0", {31'd0, switch_p}, 32'd1);
    req = 3'b100;
    step();
    check_val("s4_grant2", {29'd0, grant}, 32'd4);
    check_val("s4_disp2", {16'd0, disp_data}, 32'h00000C0C);
    check_val("s4_sw2", {31'd0, switch_p}, 32'd1);
    step();
    check_val("s4_grant2_hold", {29'd0, grant}, 32'd4);
    check_val("s4_sw_off", {31'd0, switch_p}, 32'd0);
    $display("[TB] scenario 4 early release done, %0d checks so far", tests_run);

    // Scenario 5: asynchronous reset in the middle of a window.
    do_reset();
    data0 = 16'h1111;
    data1 = 16'h2222;
    data2 = 16'h3333;
    req   = 3'b111;
    repeat (3) step();
    check_val("s5_pre_grant", {29'd0, grant}, 32'd1);
    check_val("s5_pre_disp", {16'd0, disp_data}, 32'h00001111);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("s5_async_grant", {29'd0, grant}, 32'd0);
    check_val("s5_async_disp", {16'd0, disp_data}, 32'd0);
    check_val("s5_async_strobes", {30'd0, scan_tick, switch_p}, 32'd0);
    step();
    check_val("s5_held_grant", {29'd0, grant}, 32'd0);
    rst_n = 1'b1;
    step();
    check_val("s5_first_grant", {29'd0, grant}, 32'd1);
    check_val("s5_first_disp", {16'd0, disp_data}, 32'h00001111);
    check_val("s5_first_sw", {31'd0, switch_p}, 32'd1);
    $display("[TB] scenario 5 mid-window reset done, %0d checks so far", tests_run);

    // Scenario 6: single requester releases, nothing else pending -> idle.
    do_reset();
    data1 = 16'h5A5A;
    req   = 3'b010;
    step();
    check_val("s6_grant", {29'd0, grant}, 32'd2);
    step();
    req = 3'b000;
    step();
    check_val("s6_idle_grant", {29'd0, grant}, 32'd0);
    check_val("s6_idle_disp", {16'd0, disp_data}, 32'h00005A5A);
    check_val("s6_idle_sw", {31'd0, switch_p}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      check_val("s6_retain", {13'd0, grant, disp_data}, 32'h00005A5A);
      check_val("s6_no_sw", {31'd0, switch_p}, 32'd0);
    end
    // A new request from 0 follows last grantee 1 in the ring.
    data0 = 16'h7777;
    req   = 3'b001;
    step();
    check_val("s6_regrant", {29'd0, grant}, 32'd1);
    check_val("s6_regrant_disp", {16'd0, disp_data}, 32'h00007777);
    check_val("s6_regrant_sw", {31'd0, switch_p}, 32'd1);
    $display("[TB] scenario 6 release to idle done, %0d checks so far", tests_run);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
